// File: rtl/mem_ctrl_arb.sv
// rtl/mem_ctrl_arb.sv - byte-serial RAM/IO bus master arbitrating LSB data and instruction-fetch requests
// Optional macro MC_IO_STALL_EN: holds IO-region write bytes while io_buffer_full is set.
module mem_ctrl_arb #(
  parameter int ADDR_W = 32,
  parameter int IF_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rollback,
  input  logic              lsb_en,
  input  logic              lsb_wr,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [2:0]        lsb_len,
  input  logic [31:0]       lsb_w_data,
  output logic              lsb_done,
  output logic [31:0]       lsb_r_data,
  input  logic              if_en,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_COOL} state_t;

  localparam logic       SRC_DATA = 1'b0;
  localparam logic       SRC_IF   = 1'b1;
  localparam logic [2:0] IF_LEN_L = IF_LEN[2:0];

  state_t            state_q, state_d;
  logic              src_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [2:0]        len_q;
  logic [2:0]        k_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rbuf_q;
  logic [31:0]       rbuf_merged;
  logic [31:0]       lsb_r_data_q;
  logic [31:0]       if_data_q;
  logic              lsb_done_q;
  logic              if_done_q;
  logic              accept;
  logic              rd_last;
  logic              wr_last;
  logic              io_stall;
  logic [1:0]        cap_idx;

  function automatic logic [2:0] norm_len(input logic [2:0] l);
    case (l)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign accept  = !rollback && (lsb_en || if_en);
  // In RD, k counts cycles; the byte captured this cycle was addressed k-1 cycles after acceptance.
  assign rd_last = (k_q == len_q);
  assign wr_last = (k_q == len_q - 3'd1);
  assign cap_idx = k_q[1:0] - 2'd1;

`ifdef MC_IO_STALL_EN
  assign io_stall = (state_q == S_WR) && (mem_a_q[17:16] == 2'b11) && io_buffer_full;
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign io_stall = 1'b0;
`endif

  always_comb begin
    rbuf_merged = rbuf_q;
    rbuf_merged[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (lsb_en && lsb_wr) ? S_WR : S_RD;
        end
      end
      S_RD: begin
        if (rollback) begin
          state_d = S_IDLE;
        end else if (rd_last) begin
          state_d = S_COOL;
        end
      end
      S_WR: begin
        if (!io_stall && wr_last) begin
          state_d = S_COOL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
    if (state_q == S_WR) begin
      mem_dout = wdata_q[{k_q[1:0], 3'b000} +: 8];
      mem_wr   = rdy && !io_stall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q        <= SRC_DATA;
      base_q       <= '0;
      mem_a_q      <= '0;
      len_q        <= 3'd0;
      k_q          <= 3'd0;
      wdata_q      <= 32'h0;
      rbuf_q       <= 32'h0;
      lsb_r_data_q <= 32'h0;
      if_data_q    <= 32'h0;
      lsb_done_q   <= 1'b0;
      if_done_q    <= 1'b0;
    end else if (rdy) begin
      lsb_done_q <= 1'b0;
      if_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            src_q   <= lsb_en ? SRC_DATA : SRC_IF;
            base_q  <= lsb_en ? lsb_addr : if_addr;
            mem_a_q <= lsb_en ? lsb_addr : if_addr;
            len_q   <= lsb_en ? norm_len(lsb_len) : IF_LEN_L;
            wdata_q <= lsb_w_data;
            k_q     <= 3'd0;
            rbuf_q  <= 32'h0;
          end
        end
        S_RD: begin
          if (rollback) begin
            k_q <= 3'd0;
          end else begin
            if (k_q != 3'd0) begin
              rbuf_q <= rbuf_merged;
            end
            if (rd_last) begin
              k_q <= 3'd0;
              if (src_q == SRC_IF) begin
                if_done_q <= 1'b1;
                if_data_q <= rbuf_merged;
              end else begin
                lsb_done_q   <= 1'b1;
                lsb_r_data_q <= rbuf_merged;
              end
            end else begin
              k_q <= k_q + 3'd1;
              if (k_q + 3'd1 < len_q) begin
                mem_a_q <= base_q + ADDR_W'(k_q + 3'd1);
              end
            end
          end
        end
        S_WR: begin
          if (!io_stall) begin
            if (wr_last) begin
              k_q        <= 3'd0;
              lsb_done_q <= 1'b1;
            end else begin
              k_q     <= k_q + 3'd1;
              mem_a_q <= base_q + ADDR_W'(k_q + 3'd1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign lsb_done   = lsb_done_q;
  assign if_done    = if_done_q;
  assign lsb_r_data = lsb_r_data_q;
  assign if_data    = if_data_q;
  assign mem_a      = mem_a_q;

endmodule
